// File: rtl/apb_master_ctrl_if.sv
//------------------------------------------------------------------------------
// apb_master_ctrl_if
// Bundles the command port, response port and APB4 bus of apb_master_ctrl.
//   master modport : view of the APB initiator (apb_master_ctrl)
//   slave  modport : view of the environment (command source, response sink
//                    and APB completer)
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata/cmd_strb : command port
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout         : response port
//   psel/penable/paddr/pwrite/pwdata/pstrb/prdata/pready/pslverr : APB4 bus
//------------------------------------------------------------------------------
interface apb_master_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              psel;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output psel, penable, paddr, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  psel, penable, paddr, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_ctrl.sv
//------------------------------------------------------------------------------
// apb_master_ctrl
// APB4 initiator: accepts one read/write command at a time on a valid/ready
// command port, runs the APB SETUP/ACCESS sequence and returns read data and
// error status on a valid/ready response port. A wait-state counter aborts
// transfers to a slave that never raises pready (TIMEOUT=0 disables it).
// Ports:
//   clk  : clock
//   rstn : synchronous active-low reset
//   bus  : apb_master_ctrl_if.master (command, response and APB4 signals)
// All bus outputs are registered except cmd_ready, which decodes the state.
//------------------------------------------------------------------------------
module apb_master_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    rstn,
    apb_master_ctrl_if.master       bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Counter value seen during the TIMEOUT-th wait cycle of ACCESS.
    localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            r_state,       w_state;
    logic              r_psel,        w_psel;
    logic              r_penable,     w_penable;
    logic [ADDR_W-1:0] r_paddr,       w_paddr;
    logic              r_pwrite,      w_pwrite;
    logic [DATA_W-1:0] r_pwdata,      w_pwdata;
    logic [STRB_W-1:0] r_pstrb,       w_pstrb;
    logic              r_rsp_valid,   w_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata,   w_rsp_rdata;
    logic              r_rsp_err,     w_rsp_err;
    logic              r_rsp_timeout, w_rsp_timeout;
    logic [CNT_W-1:0]  r_cnt,         w_cnt;

    // Next-state and next-output logic
    always_comb begin
        w_state       = r_state;
        w_psel        = r_psel;
        w_penable     = r_penable;
        w_paddr       = r_paddr;
        w_pwrite      = r_pwrite;
        w_pwdata      = r_pwdata;
        w_pstrb       = r_pstrb;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_err     = r_rsp_err;
        w_rsp_timeout = r_rsp_timeout;
        w_cnt         = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_paddr   = bus.cmd_addr;
                    w_pwrite  = bus.cmd_write;
                    w_pwdata  = bus.cmd_wdata;
                    // Reads drive no strobes on APB4.
                    w_pstrb   = bus.cmd_write ? bus.cmd_strb : '0;
                    w_psel    = 1'b1;
                    w_penable = 1'b0;
                    w_state   = ST_SETUP;
                end
            end

            ST_SETUP: begin
                w_penable = 1'b1;
                w_cnt     = '0;
                w_state   = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (bus.pready) begin
                    // pready has priority over a timeout in the same cycle.
                    w_rsp_rdata   = r_pwrite ? '0 : bus.prdata;
                    w_rsp_err     = bus.pslverr;
                    w_rsp_timeout = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_state       = ST_RESP;
                end else if ((TIMEOUT > 0) && (r_cnt == LP_TO_LAST)) begin
                    w_rsp_rdata   = '0;
                    w_rsp_err     = 1'b1;
                    w_rsp_timeout = 1'b1;
                    w_rsp_valid   = 1'b1;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_state       = ST_RESP;
                end else if (TIMEOUT > 0) begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_state     = ST_IDLE;
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state;
            r_psel        <= w_psel;
            r_penable     <= w_penable;
            r_paddr       <= w_paddr;
            r_pwrite      <= w_pwrite;
            r_pwdata      <= w_pwdata;
            r_pstrb       <= w_pstrb;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_err     <= w_rsp_err;
            r_rsp_timeout <= w_rsp_timeout;
            r_cnt         <= w_cnt;
        end
    end

    // Gated by rstn so no command is taken while reset is being applied.
    assign bus.cmd_ready   = (r_state == ST_IDLE) && rstn;
    assign bus.psel        = r_psel;
    assign bus.penable     = r_penable;
    assign bus.paddr       = r_paddr;
    assign bus.pwrite      = r_pwrite;
    assign bus.pwdata      = r_pwdata;
    assign bus.pstrb       = r_pstrb;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_ctrl.sv
//------------------------------------------------------------------------------
// tb_apb_master_ctrl
// Directed bench for apb_master_ctrl (TIMEOUT=8). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
//------------------------------------------------------------------------------
module tb_apb_master_ctrl;
    logic clk;
    logic rstn;
    int   n_chk;
    int   n_err;

    apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command and lets it be accepted at the next edge.
    task automatic issue(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_strb  = strb;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Acts as the APB completer: raises pready on ACCESS cycle waits+1.
    // Returns ACCESS-cycle count, psel-cycle count and edges until rsp_valid.
    task automatic wait_rsp(input string tag, input int waits, input logic err_in,
                            input logic [31:0] rd, input logic [31:0] exp_addr,
                            output int n_pen, output int n_sel, output int n_edges);
        int bad_addr;
        bad_addr = 0;
        n_pen    = 0;
        n_sel    = 0;
        n_edges  = 0;
        while (!bus.rsp_valid && n_edges < 40) begin
            if (bus.penable) n_pen++;
            if (bus.psel) n_sel++;
            if (bus.psel && bus.paddr !== exp_addr) bad_addr++;
            bus.pready  = bus.penable && (n_pen == waits + 1);
            bus.pslverr = bus.pready && err_in;
            bus.prdata  = rd;
            tick();
            n_edges++;
        end
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        chk_val({tag, "_rsp_seen"}, 64'(bus.rsp_valid), 64'd1);
        chk_val({tag, "_paddr_stable"}, 64'(bad_addr), 64'd0);
    endtask

    initial begin
        int np, ns, ne;
        int unstable;
        logic [31:0] held_rdata;

        n_chk = 0;
        n_err = 0;
        rstn          = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b1;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        // Reset state
        tick();
        tick();
        chk_val("rst_psel",      64'(bus.psel), 64'd0);
        chk_val("rst_penable",   64'(bus.penable), 64'd0);
        chk_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk_val("rst_paddr",     64'(bus.paddr), 64'd0);
        chk_val("rst_pstrb",     64'(bus.pstrb), 64'd0);
        chk_val("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        rstn = 1'b1;
        #1;
        chk_val("rel_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // Zero-wait write
        issue(1'b1, 32'h04, 32'h0BADF00D, 4'hF);
        chk_val("wr_setup_psel",    64'(bus.psel), 64'd1);
        chk_val("wr_setup_penable", 64'(bus.penable), 64'd0);
        chk_val("wr_pstrb",         64'(bus.pstrb), 64'hF);
        chk_val("wr_pwrite",        64'(bus.pwrite), 64'd1);
        chk_val("wr_pwdata",        64'(bus.pwdata), 64'h0BADF00D);
        chk_val("wr_cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
        wait_rsp("wr", 0, 1'b0, 32'hFFFF_FFFF, 32'h04, np, ns, ne);
        chk_val("wr_penable_cycles", 64'(np), 64'd1);
        chk_val("wr_psel_cycles",    64'(ns), 64'd2);
        chk_val("wr_latency",        64'(ne), 64'd2);
        chk_val("wr_psel_after",     64'(bus.psel), 64'd0);
        chk_val("wr_rsp_err",        64'(bus.rsp_err), 64'd0);
        chk_val("wr_rsp_rdata",      64'(bus.rsp_rdata), 64'd0);
        tick();
        chk_val("wr_rsp_done",  64'(bus.rsp_valid), 64'd0);
        chk_val("wr_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // Read with 3 wait states
        issue(1'b0, 32'h08, 32'h5555_5555, 4'hF);
        chk_val("rd_pstrb",  64'(bus.pstrb), 64'd0);
        chk_val("rd_pwrite", 64'(bus.pwrite), 64'd0);
        wait_rsp("rd", 3, 1'b0, 32'h12345678, 32'h08, np, ns, ne);
        chk_val("rd_penable_cycles", 64'(np), 64'd4);
        chk_val("rd_latency",        64'(ne), 64'd5);
        chk_val("rd_rsp_rdata",      64'(bus.rsp_rdata), 64'h12345678);
        chk_val("rd_rsp_err",        64'(bus.rsp_err), 64'd0);
        tick();

        // Read with pslverr on the pready cycle
        issue(1'b0, 32'h0C, 32'h0, 4'h0);
        wait_rsp("slverr", 1, 1'b1, 32'hCAFE0001, 32'h0C, np, ns, ne);
        chk_val("slverr_err",     64'(bus.rsp_err), 64'd1);
        chk_val("slverr_timeout", 64'(bus.rsp_timeout), 64'd0);
        chk_val("slverr_rdata",   64'(bus.rsp_rdata), 64'hCAFE0001);
        tick();

        // Timeout: pready never rises
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        wait_rsp("to", 100, 1'b0, 32'hFFFF_FFFF, 32'h20, np, ns, ne);
        chk_val("to_penable_cycles", 64'(np), 64'd8);
        chk_val("to_psel_after",     64'(bus.psel), 64'd0);
        chk_val("to_err",            64'(bus.rsp_err), 64'd1);
        chk_val("to_timeout",        64'(bus.rsp_timeout), 64'd1);
        chk_val("to_rdata",          64'(bus.rsp_rdata), 64'd0);
        tick();

        // pready arrives on the 8th ACCESS cycle: normal completion
        issue(1'b0, 32'h24, 32'h0, 4'h0);
        wait_rsp("to8", 7, 1'b0, 32'hA5A5A5A5, 32'h24, np, ns, ne);
        chk_val("to8_penable_cycles", 64'(np), 64'd8);
        chk_val("to8_timeout",        64'(bus.rsp_timeout), 64'd0);
        chk_val("to8_err",            64'(bus.rsp_err), 64'd0);
        chk_val("to8_rdata",          64'(bus.rsp_rdata), 64'hA5A5A5A5);
        tick();

        // Back-to-back with response back-pressure
        bus.rsp_ready = 1'b0;
        issue(1'b0, 32'h30, 32'h0, 4'h0);
        wait_rsp("bb1", 0, 1'b0, 32'h0000BEEF, 32'h30, np, ns, ne);
        held_rdata    = bus.rsp_rdata;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h40;
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.cmd_ready !== 1'b0) unstable++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== held_rdata ||
                bus.rsp_err !== 1'b0) unstable++;
        end
        chk_val("bb_hold_stable", 64'(unstable), 64'd0);
        chk_val("bb_rdata",       64'(held_rdata), 64'h0000BEEF);
        bus.rsp_ready = 1'b1;
        tick();
        chk_val("bb_rsp_done",  64'(bus.rsp_valid), 64'd0);
        chk_val("bb_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk_val("bb_idle_psel", 64'(bus.psel), 64'd0);
        tick();
        bus.cmd_valid = 1'b0;
        chk_val("bb2_setup_psel",    64'(bus.psel), 64'd1);
        chk_val("bb2_setup_penable", 64'(bus.penable), 64'd0);
        chk_val("bb2_paddr",         64'(bus.paddr), 64'h40);
        wait_rsp("bb2", 1, 1'b0, 32'h00001234, 32'h40, np, ns, ne);
        chk_val("bb2_rdata", 64'(bus.rsp_rdata), 64'h00001234);
        tick();

        // Reset during ACCESS
        issue(1'b0, 32'h50, 32'h0, 4'h0);
        tick();
        chk_val("rsta_penable", 64'(bus.penable), 64'd1);
        rstn = 1'b0;
        tick();
        chk_val("rsta_psel",      64'(bus.psel), 64'd0);
        chk_val("rsta_penable0",  64'(bus.penable), 64'd0);
        chk_val("rsta_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk_val("rsta_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        rstn = 1'b1;
        #1;
        chk_val("rsta_cmd_ready1", 64'(bus.cmd_ready), 64'd1);
        issue(1'b1, 32'h60, 32'hDEADBEEF, 4'h3);
        chk_val("rsta_pstrb", 64'(bus.pstrb), 64'h3);
        wait_rsp("rsta_wr", 0, 1'b0, 32'h0, 32'h60, np, ns, ne);
        chk_val("rsta_latency", 64'(ne), 64'd2);
        chk_val("rsta_err",     64'(bus.rsp_err), 64'd0);
        tick();
        chk_val("rsta_done", 64'(bus.cmd_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
